// File: rtl/vector_shift_issue.sv
// vector_shift_issue: issue/writeback sequencer for vector shifts.
// Optional macro VSHIFT_AMT_TRUNC_EN masks shift amounts to log2(SEW) bits.
module vector_shift_issue #(
  parameter int VLEN = 512,
  parameter int XLEN = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2:0]                   shift_op_in,
  input  logic [1:0]                   sew_in,
  input  logic [1:0]                   src_sel,
  input  logic [VLEN-1:0]              vs1_data,
  input  logic [XLEN-1:0]              rs1_data,
  input  logic [4:0]                   imm5,
  input  logic [VLEN-1:0]              vs2_data,
  input  logic [$clog2(VLEN/8):0]      vl,
  input  logic                         vm,
  input  logic [VLEN-1:0]              v0_mask,
  input  logic [VLEN-1:0]              vd_old,
  output logic [VLEN-1:0]              dataA,
  output logic [VLEN-1:0]              dataB,
  output logic [2:0]                   shift_op,
  output logic [1:0]                   sew,
  input  logic [VLEN-1:0]              shift_result,
  output logic                         wb_valid,
  input  logic                         wb_ready,
  output logic [VLEN-1:0]              wb_data,
  input  logic                         flush
);

  localparam int NB  = VLEN / 8;
  localparam int NW  = VLEN / 64;
  localparam int VLW = $clog2(VLEN/8) + 1;
  localparam int IW  = $clog2(VLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t state, state_n;

  logic            accept;
  logic [63:0]     rs1_x;
  logic [63:0]     sc;
  logic [63:0]     sc_rep;
  logic [VLEN-1:0] a_raw;
  logic [VLEN-1:0] a_n;
  logic [VLEN-1:0] a_q, b_q, m_q, old_q;
  logic [VLEN-1:0] wb_q, wb_n;
  logic [2:0]      op_q;
  logic [1:0]      sew_q;
  logic [VLW-1:0]  vl_q;
  logic            vm_q;
  logic [VLW-1:0]  vlmax;
  logic [VLW-1:0]  evl;
  logic [IW-1:0]   idx;
  logic            en;

  if (XLEN >= 64) begin : g_rs1_trunc
    assign rs1_x = rs1_data[63:0];
  end else begin : g_rs1_sext
    assign rs1_x = {{(64-XLEN){rs1_data[XLEN-1]}}, rs1_data};
  end

  // Scalar source (rs1 or imm5) replicated at SEW granularity
  always_comb begin
    sc = (src_sel == 2'b01) ? rs1_x : {59'd0, imm5};
    case (sew_in)
      2'b00:   sc_rep = {8{sc[7:0]}};
      2'b01:   sc_rep = {4{sc[15:0]}};
      2'b10:   sc_rep = {2{sc[31:0]}};
      default: sc_rep = sc;
    endcase
  end

  // Select the shift-amount operand; reserved src_sel acts as VV
  always_comb begin
    a_raw = vs1_data;
    unique case (1'b1)
      src_sel == 2'b01,
      src_sel == 2'b10: a_raw = {NW{sc_rep}};
      default:          a_raw = vs1_data;
    endcase
  end

`ifdef VSHIFT_AMT_TRUNC_EN
  logic [63:0] amt_msk;

  // Keep only the low log2(SEW) bits of each shift amount
  always_comb begin
    case (sew_in)
      2'b00:   amt_msk = {8{8'h07}};
      2'b01:   amt_msk = {4{16'h000f}};
      2'b10:   amt_msk = {2{32'h0000_001f}};
      default: amt_msk = 64'h3f;
    endcase
  end

  assign a_n = a_raw & {NW{amt_msk}};
`else
  assign a_n = a_raw;
`endif

  assign accept = in_valid && in_ready && !flush;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state; flush forces IDLE over every handshake
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (in_valid) state_n = EXEC;
      EXEC:    state_n = WB;
      WB:      if (wb_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready = (state == IDLE);
    wb_valid = (state == WB);
  end

  // Effective vl and per-byte merge of result with old destination
  always_comb begin
    vlmax = VLW'(NB >> sew_q);
    evl   = (vl_q < vlmax) ? vl_q : vlmax;
    wb_n  = old_q;
    idx   = '0;
    en    = 1'b0;
    for (int j = 0; j < NB; j++) begin
      idx = IW'(j >> sew_q);
      en  = (idx < IW'(evl)) && (vm_q || m_q[idx]);
      if (en) wb_n[j*8 +: 8] = shift_result[j*8 +: 8];
    end
  end

  // Operand capture on accept, merged result capture in EXEC
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      m_q   <= '0;
      old_q <= '0;
      op_q  <= '0;
      sew_q <= '0;
      vl_q  <= '0;
      vm_q  <= 1'b0;
      wb_q  <= '0;
    end else begin
      if (accept) begin
        a_q   <= a_n;
        b_q   <= vs2_data;
        m_q   <= v0_mask;
        old_q <= vd_old;
        op_q  <= shift_op_in;
        sew_q <= sew_in;
        vl_q  <= vl;
        vm_q  <= vm;
      end
      if (state == EXEC && !flush) wb_q <= wb_n;
    end
  end

  assign dataA    = a_q;
  assign dataB    = b_q;
  assign shift_op = op_q;
  assign sew      = sew_q;
  assign wb_data  = wb_q;

endmodule
